native_mem_mmio_bridge: RTL
===========================

// Module: native_mem_mmio_bridge
// PURPOSE
//  Parametrised memory/MMIO slave for the picorv32 native interface (mem_valid/mem_ready) in test SoCs.
//  Serves a word-addressed RAM with configurable wait states, plus NUM_CH byte-output channels.
//  Each channel is buffered by a FIFO with ready/valid backpressure, and bus errors are flagged.
//  Successor to the fixed single-byte, zero-latency test memory: adds wait states, channels, FIFOs and status reads.
// PARAMETERS
//  MEM_WORDS    4096           RAM depth in 32-bit words (power of 2)
//  WAIT_STATES  0              extra cycles inserted before mem_ready (0..15)
//  NUM_CH       2              byte-output channels (1..8)
//  FIFO_DEPTH   4              entries per channel FIFO (power of 2, >=2)
//  MMIO_BASE    32'h1000_0000  channel k data/status register at MMIO_BASE + 4*k
//  INIT_FILE    "firmware.hex" $readmemh image for RAM ("" = no init)
// PORTS
//  clk            in   1         single clock, all logic on posedge
//  reset          in   1         synchronous, active-high
//  mem_valid      in   1         CPU request valid, held until mem_ready
//  mem_instr      in   1         instruction fetch (monitor only)
//  mem_addr       in   32        byte address, [1:0] ignored
//  mem_wdata      in   32        write data
//  mem_wstrb      in   4         byte enables; 0 = read
//  mem_ready      out  1         one-cycle completion pulse
//  mem_rdata      out  32        read data, valid while mem_ready=1
//  out_valid      out  NUM_CH    channel k FIFO non-empty
//  out_ready      in   NUM_CH    channel k consumer accepts
//  out_data       out  8*NUM_CH  channel k head byte at [8k+7:8k]
//  bus_err        out  1         sticky: access outside RAM and MMIO
//  monitor_valid  out  1         mem_ready & mem_valid
//  monitor_addr   out  32        mem_addr
//  monitor_data   out  32        mem_wstrb ? mem_wdata : mem_rdata
// BEHAVIOUR
//  Reset values: mem_ready=0, mem_rdata=0, out_valid=0, bus_err=0.
//   FIFOs are emptied. FSM goes to IDLE. RAM contents are kept.
//  FSM IDLE->WAIT->RESP->IDLE.
//   IDLE: mem_valid=1 latches addr, wdata and wstrb, decodes the region, and issues the RAM read.
//   WAIT: counts WAIT_STATES cycles (skipped when 0).
//   RESP: mem_ready=1 for exactly one cycle, then IDLE.
//  Latency: request accepted in cycle T gives mem_ready in cycle T+1+WAIT_STATES. Back-to-back requests need one IDLE cycle.
//  Writes commit in the RESP cycle only: RAM bytes per wstrb, or a FIFO push. No side effect before RESP.
//  RAM region: addr>>2 < MEM_WORDS. Reads return the word; writes merge by byte enable.
//  MMIO region: MMIO_BASE <= addr < MMIO_BASE+4*NUM_CH.
//   A write with wstrb[0]=1 pushes wdata[7:0] into FIFO k.
//   If FIFO k is full, the FSM holds in WAIT (no mem_ready) until not full.
//   A pop in the same cycle does not free the slot until the next cycle.
//   A read returns {16'b0, count[7:0], 7'b0, ~full}.
//  Any other address: mem_ready is still issued (no hang), rdata=0, the write is dropped, and bus_err is set sticky until reset.
//  mem_valid dropping before RESP: transaction aborts, return to IDLE, no commit, no mem_ready.
//  FIFO: registered output, no fall-through. A push into an empty FIFO gives out_valid=1 the next cycle.
//   Pop when out_valid & out_ready. Pointers wrap modulo FIFO_DEPTH. count width is $clog2(FIFO_DEPTH)+1.
//  reset mid-transaction: the request is dropped, no commit, and no mem_ready in the reset cycle or the one after.
// STRUCTURE
//  Shared package native_mem_pkg holds:
//   FSM state encodings ST_IDLE, ST_WAIT, ST_RESP;
//   region codes REG_RAM, REG_MMIO, REG_ERR;
//   status-word field offsets.
//  Sub-module byte_fifo #(DEPTH): clk, reset, push, din[7:0], full, pop, dout[7:0], empty, count.
//   Instantiated NUM_CH times via generate.
//  The top holds the decode, the FSM, the wait counter and the RAM array (inferable as BRAM).
// TESTING
//  1. WAIT_STATES=2: write 32'hDEAD_BEEF to 0x100, then read it.
//     -> mem_ready exactly 3 cycles after accept; rdata=32'hDEAD_BEEF.
//  2. wstrb=4'b0010 write of 32'h0000_AA00 over 32'h1122_3344.
//     -> readback 32'h1122_AA44.
//  3. out_ready[0]=0, FIFO_DEPTH=4: five writes to MMIO_BASE.
//     -> the first four complete; the fifth stalls until out_ready[0]=1 for one cycle, then completes.
//     -> bytes emerge in order.
//  4. Read of MMIO_BASE+4 with 3 entries queued in FIFO_DEPTH=4.
//     -> rdata=32'h0000_0301.
//  5. Read of 32'h2000_0000.
//     -> mem_ready issued, rdata=0, bus_err=1 and held; a later valid access leaves it at 1.
//  6. reset asserted in the WAIT of a RAM write.
//     -> no mem_ready, memory unchanged, FSM IDLE, out_valid=0.

Source files
------------

// File: rtl/native_mem_mmio_bridge_pkg.sv
// Shared encodings for the native-interface memory/MMIO bridge: FSM states,
// address-decode regions and the layout of the channel status word.
package native_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_ERR  = 2'd2
  } region_e;

  // Status word: {16'b0, count[7:0], 7'b0, not_full}
  localparam int STAT_NOTFULL_BIT = 0;
  localparam int STAT_COUNT_LSB   = 8;
  localparam int STAT_COUNT_W     = 8;

endpackage

// File: rtl/native_mem_mmio_bridge_if.sv
// picorv32-style native memory bus (mem_valid/mem_ready) between a CPU master
// and the bridge slave.
interface native_mem_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/native_mem_mmio_bridge_byte_fifo.sv
// Byte FIFO with registered occupancy; the head byte is read straight from
// the storage array, so a push shows up on the output one cycle later.
module byte_fifo
  import native_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             din,
  output logic                   full,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/native_mem_mmio_bridge.sv
// Memory/MMIO slave for the picorv32 native bus: word RAM with wait states,
// NUM_CH FIFO-buffered byte channels, and a sticky bus-error flag.
module native_mem_mmio_bridge
  import native_mem_pkg::*;
#(
  parameter int          MEM_WORDS   = 4096,
  parameter int          WAIT_STATES = 0,
  parameter int          NUM_CH      = 2,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter string       INIT_FILE   = "firmware.hex"
) (
  input  logic                clk,
  input  logic                reset,
  native_mem_if.slave         bus,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [8*NUM_CH-1:0] out_data,
  output logic                bus_err,
  output logic                monitor_valid,
  output logic [31:0]         monitor_addr,
  output logic [31:0]         monitor_data
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          NCH_P2    = 2 ** CH_W;
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] MMIO_END  = MMIO_BASE + 32'(4 * NUM_CH);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  function automatic region_e decode(input logic [31:0] a);
    if ({2'b00, a[31:2]} < 32'(MEM_WORDS))     return REG_RAM;
    else if (a >= MMIO_BASE && a < MMIO_END)    return REG_MMIO;
    else                                        return REG_ERR;
  endfunction

  function automatic logic [CH_W-1:0] chan_of(input logic [31:0] a);
    return CH_W'((a - MMIO_BASE) >> 2);
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept;
  logic            commit;
  logic [31:0]     rdata;

  region_e         region_live, region_p1;
  logic [CH_W-1:0] ch_live, ch_p1;
  logic            push_live, push_p1;
  logic            blocked_live, blocked_p1;
  logic [AW-1:0]   idx_p1;
  logic [31:0]     wdata_p1;
  logic [3:0]      wstrb_p1;

  logic [31:0]       ram [MEM_WORDS];
  logic [31:0]       ram_q;
  logic              ram_we;
  logic [NCH_P2-1:0] fifo_full;
  logic [NCH_P2-1:0] fifo_push;
  logic [CNT_W-1:0]  fifo_count [NCH_P2];

  assign region_live  = decode(bus.mem_addr);
  assign ch_live      = chan_of(bus.mem_addr);
  assign push_live    = (region_live == REG_MMIO) && bus.mem_wstrb[0];
  assign blocked_live = push_live && fifo_full[ch_live];
  assign blocked_p1   = push_p1 && fifo_full[ch_p1];

  // Stage p0 -> p1: request capture in IDLE, then wait/backpressure, then one RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          accept  = 1'b1;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_STATES == 0 && !blocked_live) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.mem_valid)   state_d = ST_IDLE;
        else if (cnt_q != '0) cnt_d   = cnt_q - 4'd1;
        else if (!blocked_p1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bus_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && region_p1 == REG_ERR) bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      region_p1 <= region_live;
      ch_p1     <= ch_live;
      push_p1   <= push_live;
      idx_p1    <= AW'(bus.mem_addr >> 2);
      wdata_p1  <= bus.mem_wdata;
      wstrb_p1  <= bus.mem_wstrb;
    end
  end

  // Side effects only in a live, unreset RESP cycle so aborts leave no trace
  assign commit = (state_q == ST_RESP) && bus.mem_valid && !reset;
  assign ram_we = commit && (region_p1 == REG_RAM) && (wstrb_p1 != 4'b0000);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_p1[b]) ram[idx_p1][8*b +: 8] <= wdata_p1[8*b +: 8];
      end
    end
    if (accept) ram_q <= ram[AW'(bus.mem_addr >> 2)];
  end

  always_comb begin
    rdata = '0;
    if (commit) begin
      unique case (region_p1)
        REG_RAM:  rdata = ram_q;
        REG_MMIO: begin
          rdata[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count[ch_p1]);
          rdata[STAT_NOTFULL_BIT]               = ~fifo_full[ch_p1];
        end
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.mem_ready = commit;
  assign bus.mem_rdata = rdata;
  assign monitor_valid = commit & bus.mem_valid;
  assign monitor_addr  = bus.mem_addr;
  assign monitor_data  = (bus.mem_wstrb != 4'b0000) ? bus.mem_wdata : rdata;

  for (genvar k = 0; k < NCH_P2; k++) begin : g_ch
    assign fifo_push[k] = commit && push_p1 && (ch_p1 == CH_W'(k));
    if (k < NUM_CH) begin : g_fifo
      logic empty_k;
      byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push[k]),
        .din   (wdata_p1[7:0]),
        .full  (fifo_full[k]),
        .pop   (out_valid[k] & out_ready[k]),
        .dout  (out_data[8*k +: 8]),
        .empty (empty_k),
        .count (fifo_count[k])
      );
      assign out_valid[k] = ~empty_k;
    end else begin : g_pad
      assign fifo_full[k]  = 1'b0;
      assign fifo_count[k] = '0;
    end
  end

endmodule
